// File: rtl/mem_block_mover.sv
// Byte copy / fill engine driving a data memory.
// Combinational-read, clocked-write memory timing.
module mem_block_mover #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          Start,
  input  logic          Mode,
  input  logic [AW-1:0] SrcAddr,
  input  logic [AW-1:0] DstAddr,
  input  logic [AW-1:0] Length,
  input  logic [7:0]    FillValue,
  output logic          Busy,
  output logic          Done,
  output logic [AW-1:0] MemAddress,
  output logic          MemRead,
  output logic          MemWrite,
  output logic [7:0]    MemDataOut,
  input  logic [7:0]    MemDataIn
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WRITE,
    FILL,
    DONE
  } state_t;

  state_t        state;
  state_t        nextState;
  logic [AW-1:0] srcPtr;
  logic [AW-1:0] dstPtr;
  logic [AW-1:0] remaining;
  logic [7:0]    holdReg;
  logic [7:0]    fillReg;
  logic          modeReg;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nextState;
  end

  // Operand latch and pointer/count updates
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      srcPtr    <= '0;
      dstPtr    <= '0;
      remaining <= '0;
      holdReg   <= '0;
      fillReg   <= '0;
      modeReg   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Start) begin
            srcPtr    <= SrcAddr;
            dstPtr    <= DstAddr;
            remaining <= Length;
            fillReg   <= FillValue;
            modeReg   <= Mode;
          end
        end
        READ: begin
          holdReg <= MemDataIn;
          srcPtr  <= srcPtr + 1'b1;
        end
        WRITE, FILL: begin
          dstPtr    <= dstPtr + 1'b1;
          remaining <= remaining - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next-state decode
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: begin
        if (Start) begin
          if (Length == '0) nextState = DONE;
          else if (!Mode)   nextState = READ;
          else              nextState = FILL;
        end
      end
      READ:  nextState = WRITE;
      WRITE: nextState = (remaining == 1) ? DONE : READ;
      FILL:  nextState = (remaining == 1) ? DONE : FILL;
      DONE:  nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Memory-side outputs decoded from registered state only
  always_comb begin
    Busy       = (state != IDLE);
    Done       = 1'b0;
    MemAddress = '0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    MemDataOut = '0;
    unique case (state)
      READ: begin
        MemAddress = srcPtr;
        MemRead    = 1'b1;
      end
      WRITE: begin
        MemAddress = dstPtr;
        MemWrite   = 1'b1;
        MemDataOut = holdReg;
      end
      FILL: begin
        MemAddress = dstPtr;
        MemWrite   = 1'b1;
        MemDataOut = fillReg;
      end
      DONE: Done = 1'b1;
      default: ;
    endcase
  end

  logic unusedMode;
  assign unusedMode = modeReg;

endmodule

// File: doc/mem_block_mover.md
Name: mem_block_mover

Overview:
- Sequential block-transfer engine that sits directly upstream of the data memory and drives its address, read-enable, write-enable and write-data ports.
- Performs two operations on behalf of the testbench or control path: byte copy (SRC→DST, Length bytes) and byte fill (constant→DST, Length bytes).
- Uses the memory's combinational-read / clocked-write timing; one transfer at a time, with a Start/Busy/Done handshake.

Parameters:
AW, 8, address width; memory depth 2**AW; also width of Length and address counters

Ports:
clk  input  1  clock, all state updates on posedge
reset_n  input  1  asynchronous active-low reset
Start  input  1  request pulse; sampled only in IDLE
Mode  input  1  0 = copy, 1 = fill; latched with Start
SrcAddr  input  AW  copy source base address; latched with Start
DstAddr  input  AW  destination base address; latched with Start
Length  input  AW  byte count; 0 = no-op; latched with Start
FillValue  input  8  fill byte; latched with Start
Busy  output  1  high from the cycle after an accepted Start through the DONE cycle inclusive
Done  output  1  one-cycle completion pulse
MemAddress  output  AW  to memory address input
MemRead  output  1  to memory read enable
MemWrite  output  1  to memory write enable
MemDataOut  output  8  to memory write-data input
MemDataIn  input  8  from memory read-data output (combinational read)

Behaviour:
- States: IDLE, READ, WRITE, FILL, DONE. State, counters and registers reset asynchronously on reset_n=0.
- Reset values:
  - state = IDLE.
  - Busy = 0, Done = 0, MemRead = 0, MemWrite = 0.
  - MemAddress = 0, MemDataOut = 0.
  - Internal src/dst pointers, remaining count and hold register = 0.
- IDLE:
  - All memory controls are low.
  - On posedge with Start=1: latch Mode, SrcAddr, DstAddr, Length and FillValue.
  - Next state: DONE if Length=0; else READ if Mode=0; else FILL.
- READ:
  - MemAddress = src pointer, MemRead = 1, MemWrite = 0.
  - On posedge: hold register ← MemDataIn, src pointer += 1; go to WRITE.
- WRITE:
  - MemAddress = dst pointer, MemWrite = 1, MemRead = 0, MemDataOut = hold register.
  - On posedge: dst pointer += 1, remaining −= 1; go to DONE if remaining was 1, else READ.
- FILL:
  - MemAddress = dst pointer, MemWrite = 1, MemDataOut = latched FillValue.
  - On posedge: dst pointer += 1, remaining −= 1; go to DONE if remaining was 1.
- DONE:
  - Done = 1, Busy = 1, memory controls low.
  - Go to IDLE next cycle.
  - Start is not accepted in this state.
- Latency, measured from the Start-sampling edge T0:
  - Copy of N bytes: 2N cycles of READ/WRITE, then DONE at cycle 2N+1.
  - Fill of N bytes: DONE at cycle N+1.
  - Length 0: DONE at cycle 1, no memory write.
- Outputs MemAddress, MemRead, MemWrite and MemDataOut are decoded from registered state only; no combinational path from Start or MemDataIn to them.
- Pointer arithmetic is modulo 2**AW: the address after 2**AW−1 wraps to 0 with no error flag.
- Overlapping copy is strictly ascending byte-by-byte. If DST is in (SRC, SRC+Length), already-written bytes are re-read, giving forward propagation. This is defined behaviour, not an error.
- Start while Busy=1 is ignored entirely; latched operands are unchanged.
- Input changes on SrcAddr, DstAddr, Length, Mode and FillValue after the accepting edge have no effect.
- When reset_n is asserted mid-transfer, all outputs drop immediately (asynchronous) and Done is not pulsed.
  - Bytes already written remain in memory.
  - A write in the reset cycle is not guaranteed.
- MemRead and MemWrite are never high in the same cycle.
- MemWrite is high only in WRITE and FILL.

Test Plan:
1. Preload M[0x10..0x13] = 0xA1, 0xB2, 0xC3, 0xD4; Start copy Src=0x10, Dst=0x40, Len=4.
   - Required: M[0x40..0x43] = 0xA1, 0xB2, 0xC3, 0xD4.
   - Done pulses exactly at T0+9; Busy high for cycles 1..9; exactly 4 write cycles.
2. Fill Dst=0x80, Len=3, FillValue=0x5A.
   - Required: M[0x80..0x82] = 0x5A; M[0x83] unchanged; Done at T0+4.
3. Len=0, either mode.
   - Required: no MemWrite ever high; Done at T0+1; memory unchanged.
4. Wrap fill Dst=0xFE, Len=4, FillValue=0x33.
   - Required: M[0xFE], M[0xFF], M[0x00], M[0x01] = 0x33; M[0x02] unchanged.
5. Overlapping copy with M[0x20]=0x11, M[0x21]=0x22, Src=0x20, Dst=0x21, Len=2.
   - Required: M[0x21]=0x11, M[0x22]=0x11.
   - Also pulse Start during Busy with Len=5: the second request is ignored and only one Done occurs.
6. Start a copy of Len=8; deassert reset_n after the 3rd WRITE.
   - Required: Busy, MemWrite and Done go to 0 immediately; first 3 destination bytes are written; no Done pulse.
   - After release, a new fill of Len=1 completes normally at T0+2.
